// File: rtl/e203_lsu_lockstep_chk_pkg.sv
// Shared widths, fault-cause bit positions and FSM state type for the LSU lockstep checker.
// A write-back record is {wdat, itag, badaddr, err, ld, st, buserr}, packed by concatenation.
package e203_lsu_lockstep_chk_pkg;

  localparam int E203_XLEN       = 32;
  localparam int E203_ITAG_WIDTH = 4;
  localparam int E203_ADDR_SIZE  = 32;

  localparam int E203_LSU_WBCK_REC_W = E203_XLEN + E203_ITAG_WIDTH + E203_ADDR_SIZE + 4;

  localparam int FAULT_CAUSE_MISMATCH = 0;
  localparam int FAULT_CAUSE_TIMEOUT  = 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } lsc_state_e;

endpackage

// File: rtl/e203_lsu_lockstep_chk_fifo.sv
// Primary-record skew queue: flop-based circular buffer with no write-to-read bypass,
// so a record written in one cycle is visible at the head the next cycle at the earliest.
module e203_lsu_lockstep_chk_fifo #(
  parameter int DP = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat
);

  localparam int PW = (DP > 1) ? $clog2(DP) : 1;
  localparam int CW = $clog2(DP + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(DP - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DP);

  logic [DW-1:0] mem [DP];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          wen;
  logic          ren;

  assign i_rdy = (cnt != FULL_CNT);
  assign o_vld = (cnt != '0);
  assign o_dat = mem[rptr];
  assign wen   = i_vld & i_rdy;
  assign ren   = o_vld & o_rdy;

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[wptr] <= i_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wen) begin
        wptr <= (wptr == LAST_IDX) ? '0 : wptr + 1'b1;
      end
      if (ren) begin
        rptr <= (rptr == LAST_IDX) ? '0 : rptr + 1'b1;
      end
      case ({wen, ren})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/e203_lsu_lockstep_chk.sv
// Lockstep checker: queues primary LSU write-back records, compares each with the shadow core's
// record in order, forwards matches, and latches a sticky fault. Optional timeout: E203_LOCKSTEP_TMO_EN.
module e203_lsu_lockstep_chk
  import e203_lsu_lockstep_chk_pkg::*;
#(
  parameter int               FIFO_DP = 4,
  parameter int               TMO_W   = 6,
  parameter logic [TMO_W-1:0] TMO_MAX = TMO_W'(40)
) (
  input  logic                       clk,
  input  logic                       rst_n,

  input  logic                       p_valid,
  output logic                       p_ready,
  input  logic [E203_XLEN-1:0]       p_wdat,
  input  logic [E203_ITAG_WIDTH-1:0] p_itag,
  input  logic [E203_ADDR_SIZE-1:0]  p_badaddr,
  input  logic                       p_err,
  input  logic                       p_ld,
  input  logic                       p_st,
  input  logic                       p_buserr,

  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [E203_XLEN-1:0]       s_wdat,
  input  logic [E203_ITAG_WIDTH-1:0] s_itag,
  input  logic [E203_ADDR_SIZE-1:0]  s_badaddr,
  input  logic                       s_err,
  input  logic                       s_ld,
  input  logic                       s_st,
  input  logic                       s_buserr,

  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [E203_XLEN-1:0]       o_wdat,
  output logic [E203_ITAG_WIDTH-1:0] o_itag,
  output logic [E203_ADDR_SIZE-1:0]  o_badaddr,
  output logic                       o_err,
  output logic                       o_ld,
  output logic                       o_st,
  output logic                       o_buserr,

  output logic                       lockstep_fault,
  output logic [1:0]                 fault_cause
);

  localparam int RW = E203_LSU_WBCK_REC_W;

  lsc_state_e state;
  lsc_state_e state_nxt;

  logic [RW-1:0] p_rec;
  logic [RW-1:0] s_rec;
  logic [RW-1:0] head_rec;
  logic [RW-1:0] o_rec;
  logic          o_vld_r;
  logic [1:0]    cause_r;

  logic in_run;
  logic fifo_i_vld;
  logic fifo_i_rdy;
  logic fifo_o_vld;
  logic pop;
  logic mismatch;
  logic tmo_hit;
  logic o_load;

  assign p_rec = {p_wdat, p_itag, p_badaddr, p_err, p_ld, p_st, p_buserr};
  assign s_rec = {s_wdat, s_itag, s_badaddr, s_err, s_ld, s_st, s_buserr};

  assign in_run     = (state == ST_RUN);
  assign p_ready    = in_run & fifo_i_rdy;
  assign fifo_i_vld = in_run & p_valid;
  // The shadow is consumed only when the output register can take the result this cycle.
  assign s_ready    = in_run & fifo_o_vld & (~o_vld_r | o_ready);
  assign pop        = s_valid & s_ready;
  assign mismatch   = pop & (head_rec != s_rec);
  assign o_load     = pop & ~mismatch;

  e203_lsu_lockstep_chk_fifo #(
    .DP (FIFO_DP),
    .DW (RW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (fifo_i_vld),
    .i_rdy (fifo_i_rdy),
    .i_dat (p_rec),
    .o_vld (fifo_o_vld),
    .o_rdy (pop),
    .o_dat (head_rec)
  );

`ifdef E203_LOCKSTEP_TMO_EN
  logic [TMO_W-1:0] tmo_cnt;

  // Measures how long the current head has waited since the last pop; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (!in_run || !fifo_o_vld || pop) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = in_run & fifo_o_vld & (tmo_cnt == TMO_MAX);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (mismatch || tmo_hit) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_r <= 2'b00;
    end else if (in_run) begin
      if (mismatch) begin
        cause_r[FAULT_CAUSE_MISMATCH] <= 1'b1;
      end
      if (tmo_hit) begin
        cause_r[FAULT_CAUSE_TIMEOUT] <= 1'b1;
      end
    end
  end

  // Entering or sitting in FAULT wipes the output so nothing stale reaches commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld_r <= 1'b0;
      o_rec   <= '0;
    end else if (state_nxt == ST_FAULT) begin
      o_vld_r <= 1'b0;
      o_rec   <= '0;
    end else if (o_load) begin
      o_vld_r <= 1'b1;
      o_rec   <= head_rec;
    end else if (o_ready) begin
      o_vld_r <= 1'b0;
    end
  end

  assign o_valid = o_vld_r;
  assign {o_wdat, o_itag, o_badaddr, o_err, o_ld, o_st, o_buserr} = o_rec;

  assign lockstep_fault = ~in_run;
  assign fault_cause    = cause_r;

endmodule

// File: tb/tb_e203_lsu_lockstep_chk.sv
// Directed bench for e203_lsu_lockstep_chk: a cycle table for pass/streaming, then hand-written
// sequences for skew fill, backpressure, mismatch, timeout and asynchronous reset.
module tb_e203_lsu_lockstep_chk;
  import e203_lsu_lockstep_chk_pkg::*;

  localparam int IW = E203_ITAG_WIDTH;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      p_valid, p_ready, s_valid, s_ready, o_valid, o_ready;
  logic [E203_XLEN-1:0]      p_wdat, s_wdat, o_wdat;
  logic [IW-1:0]             p_itag, s_itag, o_itag;
  logic [E203_ADDR_SIZE-1:0] p_badaddr, s_badaddr, o_badaddr;
  logic                      p_err, p_ld, p_st, p_buserr;
  logic                      s_err, s_ld, s_st, s_buserr;
  logic                      o_err, o_ld, o_st, o_buserr;
  logic                      lockstep_fault;
  logic [1:0]                fault_cause;

  int err_cnt = 0;
  int chk_cnt = 0;

  typedef struct {
    logic          pv;
    logic [IW-1:0] pitag;
    logic [31:0]   pwdat;
    logic          pld;
    logic          sv;
    logic [IW-1:0] sitag;
    logic [31:0]   swdat;
    logic          sld;
    logic          ordy;
    logic          e_pr;
    logic          e_sr;
    logic          e_ov;
    logic [IW-1:0] e_itag;
    logic [31:0]   e_wdat;
    logic          e_ld;
  } vec_t;

  vec_t vecs[10];

  e203_lsu_lockstep_chk dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .p_valid        (p_valid),
    .p_ready        (p_ready),
    .p_wdat         (p_wdat),
    .p_itag         (p_itag),
    .p_badaddr      (p_badaddr),
    .p_err          (p_err),
    .p_ld           (p_ld),
    .p_st           (p_st),
    .p_buserr       (p_buserr),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_wdat         (s_wdat),
    .s_itag         (s_itag),
    .s_badaddr      (s_badaddr),
    .s_err          (s_err),
    .s_ld           (s_ld),
    .s_st           (s_st),
    .s_buserr       (s_buserr),
    .o_valid        (o_valid),
    .o_ready        (o_ready),
    .o_wdat         (o_wdat),
    .o_itag         (o_itag),
    .o_badaddr      (o_badaddr),
    .o_err          (o_err),
    .o_ld           (o_ld),
    .o_st           (o_st),
    .o_buserr       (o_buserr),
    .lockstep_fault (lockstep_fault),
    .fault_cause    (fault_cause)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic setPrim(input logic v, input logic [31:0] wdat, input logic [IW-1:0] itag,
                         input logic ld);
    p_valid   = v;
    p_wdat    = wdat;
    p_itag    = itag;
    p_badaddr = ~wdat;
    p_err     = 1'b0;
    p_ld      = ld;
    p_st      = ~ld;
    p_buserr  = 1'b0;
  endtask

  task automatic setShad(input logic v, input logic [31:0] wdat, input logic [IW-1:0] itag,
                         input logic ld);
    s_valid   = v;
    s_wdat    = wdat;
    s_itag    = itag;
    s_badaddr = ~wdat;
    s_err     = 1'b0;
    s_ld      = ld;
    s_st      = ~ld;
    s_buserr  = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    setPrim(v.pv, v.pwdat, v.pitag, v.pld);
    setShad(v.sv, v.swdat, v.sitag, v.sld);
    o_ready = v.ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    setPrim(1'b0, 32'h0, '0, 1'b0);
    setShad(1'b0, 32'h0, '0, 1'b0);
    o_ready = 1'b1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    checkBit("rst_o_valid", o_valid, 1'b0);
    checkOutput("rst_o_wdat", o_wdat, 32'h0);
    checkBit("rst_fault", lockstep_fault, 1'b0);
    checkOutput("rst_cause", 32'(fault_cause), 32'h0);
    checkBit("rst_p_ready", p_ready, 1'b1);
    checkBit("rst_s_ready", s_ready, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'd1, 32'h1234_5678, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'd1, 32'h1234_5678, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0};
    vecs[2] = '{1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, 4'd1, 32'h1234_5678, 1'b1};
    vecs[3] = '{1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 4'd2, 32'hA000_0002, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0};
    vecs[5] = '{1'b1, 4'd3, 32'hA000_0003, 1'b0, 1'b1, 4'd2, 32'hA000_0002, 1'b0, 1'b1,
                1'b1, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0};
    vecs[6] = '{1'b1, 4'd0, 32'hA000_0004, 1'b1, 1'b1, 4'd3, 32'hA000_0003, 1'b0, 1'b1,
                1'b1, 1'b1, 1'b1, 4'd2, 32'hA000_0002, 1'b0};
    vecs[7] = '{1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'd0, 32'hA000_0004, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b1, 4'd3, 32'hA000_0003, 1'b0};
    vecs[8] = '{1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b1, 4'd0, 32'hA000_0004, 1'b1};
    vecs[9] = '{1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1,
                1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0};

    // Lockstep pass followed by a back-to-back stream.
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      #3;
      checkBit($sformatf("vec%0d_p_ready", i), p_ready, vecs[i].e_pr);
      checkBit($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].e_sr);
      checkBit($sformatf("vec%0d_o_valid", i), o_valid, vecs[i].e_ov);
      checkBit($sformatf("vec%0d_fault", i), lockstep_fault, 1'b0);
      if (vecs[i].e_ov) begin
        checkOutput($sformatf("vec%0d_o_itag", i), 32'(o_itag), 32'(vecs[i].e_itag));
        checkOutput($sformatf("vec%0d_o_wdat", i), o_wdat, vecs[i].e_wdat);
        checkOutput($sformatf("vec%0d_o_badaddr", i), o_badaddr, ~vecs[i].e_wdat);
        checkBit($sformatf("vec%0d_o_ld", i), o_ld, vecs[i].e_ld);
        checkBit($sformatf("vec%0d_o_st", i), o_st, ~vecs[i].e_ld);
      end
      nextCycle();
    end

    // Skew fill: four pushes fill the queue, the fifth is refused, then drain in order.
    doReset();
    for (int i = 0; i < 4; i++) begin
      setPrim(1'b1, 32'hB000_0000 + 32'(i), IW'(i), 1'b0);
      #3;
      checkBit($sformatf("fill%0d_p_ready", i), p_ready, 1'b1);
      nextCycle();
    end
    setPrim(1'b1, 32'hB000_0004, IW'(4), 1'b0);
    #3;
    checkBit("fill_full_p_ready", p_ready, 1'b0);
    nextCycle();
    setPrim(1'b0, 32'h0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      setShad(1'b1, 32'hB000_0000 + 32'(i), IW'(i), 1'b0);
      #3;
      checkBit($sformatf("drain%0d_s_ready", i), s_ready, 1'b1);
      if (i > 0) begin
        checkBit($sformatf("drain%0d_o_valid", i), o_valid, 1'b1);
        checkOutput($sformatf("drain%0d_o_itag", i), 32'(o_itag), 32'(i - 1));
      end
      nextCycle();
    end
    setShad(1'b0, 32'h0, '0, 1'b0);
    #3;
    checkBit("drain_last_o_valid", o_valid, 1'b1);
    checkOutput("drain_last_o_itag", 32'(o_itag), 32'd3);
    nextCycle();
    #3;
    checkBit("drain_done_o_valid", o_valid, 1'b0);
    checkBit("drain_done_s_ready", s_ready, 1'b0);
    checkBit("drain_done_fault", lockstep_fault, 1'b0);
    nextCycle();

    // Backpressure: output held stable for five cycles, then back-to-back release.
    doReset();
    o_ready = 1'b0;
    setPrim(1'b1, 32'hC000_0001, IW'(1), 1'b1);
    nextCycle();
    setPrim(1'b1, 32'hC000_0002, IW'(2), 1'b0);
    setShad(1'b1, 32'hC000_0001, IW'(1), 1'b1);
    #3;
    checkBit("bp_first_s_ready", s_ready, 1'b1);
    nextCycle();
    setPrim(1'b0, 32'h0, '0, 1'b0);
    setShad(1'b1, 32'hC000_0002, IW'(2), 1'b0);
    for (int i = 0; i < 5; i++) begin
      #3;
      checkBit($sformatf("bp%0d_o_valid", i), o_valid, 1'b1);
      checkOutput($sformatf("bp%0d_o_itag", i), 32'(o_itag), 32'd1);
      checkOutput($sformatf("bp%0d_o_wdat", i), o_wdat, 32'hC000_0001);
      checkBit($sformatf("bp%0d_s_ready", i), s_ready, 1'b0);
      nextCycle();
    end
    o_ready = 1'b1;
    #3;
    checkBit("bp_release_s_ready", s_ready, 1'b1);
    checkOutput("bp_release_o_itag", 32'(o_itag), 32'd1);
    nextCycle();
    setShad(1'b0, 32'h0, '0, 1'b0);
    #3;
    checkBit("bp_second_o_valid", o_valid, 1'b1);
    checkOutput("bp_second_o_itag", 32'(o_itag), 32'd2);
    checkOutput("bp_second_o_wdat", o_wdat, 32'hC000_0002);
    nextCycle();
    #3;
    checkBit("bp_done_o_valid", o_valid, 1'b0);
    nextCycle();

    // Mismatch in wdat bit 0: sticky fault, everything blocked until reset.
    doReset();
    setPrim(1'b1, 32'hD000_00FF, IW'(5), 1'b1);
    nextCycle();
    setShad(1'b1, 32'hD000_00FE, IW'(5), 1'b1);
    #3;
    checkBit("mm_pop_s_ready", s_ready, 1'b1);
    checkBit("mm_pop_fault", lockstep_fault, 1'b0);
    nextCycle();
    setPrim(1'b1, 32'hD000_0100, IW'(6), 1'b0);
    for (int i = 0; i < 4; i++) begin
      #3;
      checkBit($sformatf("mm%0d_fault", i), lockstep_fault, 1'b1);
      checkOutput($sformatf("mm%0d_cause", i), 32'(fault_cause), 32'h1);
      checkBit($sformatf("mm%0d_o_valid", i), o_valid, 1'b0);
      checkBit($sformatf("mm%0d_p_ready", i), p_ready, 1'b0);
      checkBit($sformatf("mm%0d_s_ready", i), s_ready, 1'b0);
      nextCycle();
    end

    // Mismatch in a status flag only.
    doReset();
    setPrim(1'b1, 32'hE000_0006, IW'(6), 1'b0);
    nextCycle();
    setPrim(1'b0, 32'h0, '0, 1'b0);
    setShad(1'b1, 32'hE000_0006, IW'(6), 1'b0);
    s_buserr = 1'b1;
    nextCycle();
    setShad(1'b0, 32'h0, '0, 1'b0);
    #3;
    checkBit("mmflag_fault", lockstep_fault, 1'b1);
    checkOutput("mmflag_cause", 32'(fault_cause), 32'h1);
    checkBit("mmflag_o_valid", o_valid, 1'b0);
    nextCycle();

    // Timeout: one queued record, shadow idle.
    doReset();
    setPrim(1'b1, 32'hF000_0001, IW'(7), 1'b0);
    nextCycle();
    setPrim(1'b0, 32'h0, '0, 1'b0);
`ifdef E203_LOCKSTEP_TMO_EN
    repeat (40) nextCycle();
    #3;
    checkBit("tmo_before_fault", lockstep_fault, 1'b0);
    checkOutput("tmo_before_cause", 32'(fault_cause), 32'h0);
    nextCycle();
    #3;
    checkBit("tmo_fault", lockstep_fault, 1'b1);
    checkOutput("tmo_cause", 32'(fault_cause), 32'h2);
    checkBit("tmo_p_ready", p_ready, 1'b0);
    checkBit("tmo_s_ready", s_ready, 1'b0);
    nextCycle();
`else
    repeat (1000) nextCycle();
    #3;
    checkBit("notmo_fault", lockstep_fault, 1'b0);
    checkOutput("notmo_cause", 32'(fault_cause), 32'h0);
    checkBit("notmo_s_ready", s_ready, 1'b1);
    setShad(1'b1, 32'hF000_0001, IW'(7), 1'b0);
    nextCycle();
    setShad(1'b0, 32'h0, '0, 1'b0);
    #3;
    checkBit("notmo_late_o_valid", o_valid, 1'b1);
    checkOutput("notmo_late_o_itag", 32'(o_itag), 32'd7);
    nextCycle();
`endif

    // Async reset while the queue holds three records and the output holds one.
    doReset();
    o_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setPrim(1'b1, 32'hA500_0009 + 32'(i), IW'(9 + i), 1'b0);
      nextCycle();
    end
    setPrim(1'b0, 32'h0, '0, 1'b0);
    setShad(1'b1, 32'hA500_0009, IW'(9), 1'b0);
    nextCycle();
    setShad(1'b0, 32'h0, '0, 1'b0);
    #3;
    checkBit("arst_pre_o_valid", o_valid, 1'b1);
    checkOutput("arst_pre_o_itag", 32'(o_itag), 32'd9);
    #1;
    rst_n = 1'b0;
    #1;
    checkBit("arst_o_valid", o_valid, 1'b0);
    checkOutput("arst_o_wdat", o_wdat, 32'h0);
    checkOutput("arst_o_itag", 32'(o_itag), 32'h0);
    checkBit("arst_s_ready", s_ready, 1'b0);
    checkBit("arst_p_ready", p_ready, 1'b1);
    checkBit("arst_fault", lockstep_fault, 1'b0);
    nextCycle();
    rst_n = 1'b1;
    o_ready = 1'b1;
    setShad(1'b1, 32'hA500_000A, IW'(10), 1'b0);
    for (int i = 0; i < 3; i++) begin
      #3;
      checkBit($sformatf("arst_post%0d_s_ready", i), s_ready, 1'b0);
      checkBit($sformatf("arst_post%0d_o_valid", i), o_valid, 1'b0);
      checkBit($sformatf("arst_post%0d_fault", i), lockstep_fault, 1'b0);
      nextCycle();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
